// File: rtl/adc_ila_capture_if.sv
// adc_ila_capture_if
//   Capture handshake and serialized sample stream of adc_ila_capture.
//   trigger_in  : capture request level from the ILA trigger out
//   trigger_ack : one-clock acknowledge when the capture engine re-arms
//   adc_out     : serialized 12-bit sample
//   adc_valid   : adc_out qualifier
//   armed       : capture engine waiting for a trigger edge
//   master = capture engine side, slave = consumer / trigger source side.
interface adc_ila_capture_if;
  logic        trigger_in;
  logic        trigger_ack;
  logic [11:0] adc_out;
  logic        adc_valid;
  logic        armed;

  modport master (
    input  trigger_in,
    output trigger_ack,
    output adc_out,
    output adc_valid,
    output armed
  );

  modport slave (
    output trigger_in,
    input  trigger_ack,
    input  adc_out,
    input  adc_valid,
    input  armed
  );
endinterface

// File: rtl/adc_ila_capture.sv
// adc_ila_capture
//   Pre/post-trigger capture of one ADC channel into a circular RAM, then
//   serialized readout of every 12-bit sample, oldest word first.
//   Ports:
//     adc_clk   : sole clock, rising edge
//     rst       : synchronous active-high reset
//     adc_in    : NCHAN x 128-bit words, 8 lanes of 16 bits, sample in [16k+4 +: 12]
//     chan_sel  : channel to capture, latched when ARM is entered
//     cap       : trigger / readout interface (adc_ila_capture_if.master)
//     trig_time : only with ADC_ILA_CAPTURE_TIMESTAMP_EN defined; adc_clk count
//                 latched at the accepted trigger
//
//   state | meaning
//   ------+------------------------------------------------------------
//   ARM   | writing the PRETRIG pre-trigger words, triggers ignored
//   ARMED | writing circularly, waiting for a trigger_in rising edge
//   POST  | writing the remaining post-trigger words
//   READ  | streaming the whole buffer, 8 samples per word
//   WAIT  | holdoff after readout, then one-clock trigger_ack
module adc_ila_capture #(
  parameter int NCHAN      = 1,
  parameter int DEPTH_LOG2 = 7,
  parameter int PRETRIG    = 16,
  parameter int HOLDOFF    = 32
) (
  input  logic                   adc_clk,
  input  logic                   rst,
  input  logic [NCHAN*128-1:0]   adc_in,
  input  logic [1:0]             chan_sel,
  adc_ila_capture_if.master      cap
`ifdef ADC_ILA_CAPTURE_TIMESTAMP_EN
  ,
  output logic [31:0]            trig_time
`endif
);

  localparam int N  = 1 << DEPTH_LOG2;
  localparam int AW = DEPTH_LOG2;
  localparam int CW = DEPTH_LOG2 + 1;
  localparam int RW = DEPTH_LOG2 + 3;

  localparam logic [CW-1:0] ARM_LAST  = CW'((PRETRIG == 0) ? 0 : PRETRIG - 1);
  localparam logic [CW-1:0] POST_LAST = CW'(N - PRETRIG - 1);
  localparam logic [RW-1:0] RD_LAST   = RW'(8 * N - 1);
  localparam logic [AW-1:0] PRE_A     = AW'(PRETRIG);
  localparam logic [7:0]    HOLD      = 8'(HOLDOFF);

  typedef enum logic [2:0] {ST_ARM, ST_ARMED, ST_POST, ST_READ, ST_WAIT} state_t;

  state_t         state;
  logic [1:0]     chan_q;
  logic           trig_prev;
  logic [AW-1:0]  wr_addr;
  logic [AW-1:0]  trig_addr;
  logic [AW-1:0]  rd_addr;
  logic [CW-1:0]  cnt;
  logic [RW-1:0]  rcnt;
  logic [7:0]     wcnt;
  logic           primed;
  logic [95:0]    mem [N];
  logic [95:0]    rd_data;
  logic [95:0]    wr_word;
  logic           wr_en;
  logic           trig_edge;
  logic           unused_ok;

  function automatic logic [1:0] legal_chan(input logic [1:0] c);
    return (int'(c) < NCHAN) ? c : 2'd0;
  endfunction

  // Only the 12-bit sample field of each lane is stored; the low nibbles are ignored.
  assign unused_ok = ^adc_in;

  always_comb begin
    wr_word = '0;
    for (int c = 0; c < NCHAN; c++) begin
      if (chan_q == c[1:0]) begin
        for (int k = 0; k < 8; k++) begin
          wr_word[12*k +: 12] = adc_in[128*c + 16*k + 4 +: 12];
        end
      end
    end
  end

  assign wr_en     = !rst && (state == ST_ARM || state == ST_ARMED || state == ST_POST);
  assign trig_edge = cap.trigger_in && !trig_prev;

  always_ff @(posedge adc_clk) begin
    if (wr_en) mem[wr_addr] <= wr_word;
    rd_data <= mem[rd_addr];
  end

  always_ff @(posedge adc_clk) begin
    if (rst) begin
      state           <= ST_ARM;
      chan_q          <= legal_chan(chan_sel);
      trig_prev       <= 1'b0;
      wr_addr         <= '0;
      trig_addr       <= '0;
      rd_addr         <= '0;
      cnt             <= '0;
      rcnt            <= '0;
      wcnt            <= '0;
      primed          <= 1'b0;
      cap.trigger_ack <= 1'b0;
      cap.adc_valid   <= 1'b0;
      cap.adc_out     <= '0;
      cap.armed       <= 1'b0;
    end else begin
      trig_prev       <= cap.trigger_in;
      cap.adc_valid   <= 1'b0;
      cap.adc_out     <= '0;
      cap.trigger_ack <= 1'b0;
      if (wr_en) wr_addr <= wr_addr + AW'(1);

      case (state)
        ST_ARM: begin
          if (cnt == ARM_LAST) begin
            state     <= ST_ARMED;
            cap.armed <= 1'b1;
            cnt       <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        ST_ARMED: begin
          // The word written this cycle is post-trigger word 0.
          if (trig_edge) begin
            cap.armed <= 1'b0;
            trig_addr <= wr_addr;
            cnt       <= CW'(1);
            if (POST_LAST == '0) begin
              state   <= ST_READ;
              rd_addr <= wr_addr - PRE_A;
              rcnt    <= '0;
              primed  <= 1'b0;
            end else begin
              state <= ST_POST;
            end
          end
        end

        ST_POST: begin
          if (cnt == POST_LAST) begin
            state   <= ST_READ;
            rd_addr <= trig_addr - PRE_A;
            rcnt    <= '0;
            primed  <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        ST_READ: begin
          // One priming clock fills rd_data; the next word is fetched while
          // lane 6 goes out so it lands exactly when lane 7 leaves.
          if (!primed) begin
            primed <= 1'b1;
          end else begin
            cap.adc_valid <= 1'b1;
            cap.adc_out   <= rd_data[12*rcnt[2:0] +: 12];
            if (rcnt[2:0] == 3'd6) rd_addr <= rd_addr + AW'(1);
            if (rcnt == RD_LAST) begin
              state <= ST_WAIT;
              wcnt  <= '0;
            end else begin
              rcnt <= rcnt + RW'(1);
            end
          end
        end

        ST_WAIT: begin
          if (cap.trigger_ack) begin
            state  <= ST_ARM;
            chan_q <= legal_chan(chan_sel);
            cnt    <= '0;
          end else if (wcnt == HOLD) begin
            cap.trigger_ack <= 1'b1;
          end else begin
            wcnt <= wcnt + 8'd1;
          end
        end

        default: state <= ST_ARM;
      endcase
    end
  end

`ifdef ADC_ILA_CAPTURE_TIMESTAMP_EN
  logic [31:0] ts;

  always_ff @(posedge adc_clk) begin
    if (rst) begin
      ts        <= '0;
      trig_time <= '0;
    end else begin
      ts <= ts + 32'd1;
      if (state == ST_ARMED && trig_edge) trig_time <= ts;
    end
  end
`endif

endmodule

// File: tb/tb_adc_ila_capture.sv
module tb_adc_ila_capture;
  localparam int NA = 128, PA = 16, HA = 32;
  localparam int NB = 32,  PB = 0,  HB = 4;

  logic         clk = 1'b0;
  logic         rst_a, rst_b;
  logic [127:0] adc_a;
  logic [511:0] adc_b;
  logic [1:0]   sel_a, sel_b;
  logic [31:0]  tt_a, tt_b;

  adc_ila_capture_if if_a ();
  adc_ila_capture_if if_b ();

  always #5 clk = ~clk;

  adc_ila_capture dut_a (
    .adc_clk  (clk),
    .rst      (rst_a),
    .adc_in   (adc_a),
    .chan_sel (sel_a),
    .cap      (if_a)
`ifdef ADC_ILA_CAPTURE_TIMESTAMP_EN
    ,
    .trig_time(tt_a)
`endif
  );

  adc_ila_capture #(.NCHAN(4), .DEPTH_LOG2(5), .PRETRIG(PB), .HOLDOFF(HB)) dut_b (
    .adc_clk  (clk),
    .rst      (rst_b),
    .adc_in   (adc_b),
    .chan_sel (sel_b),
    .cap      (if_b)
`ifdef ADC_ILA_CAPTURE_TIMESTAMP_EN
    ,
    .trig_time(tt_b)
`endif
  );

  int widx = 0;
  int n_chk = 0;
  int n_fail = 0;

  logic [11:0] exp_mem [2][1024];
  logic [11:0] rcv     [2][1024];
  int exp_len [2];
  int rd_ptr  [2];
  int vcnt    [2];
  int first_v [2];
  int last_v  [2];
  int ack_cnt [2];
  int last_ack[2];

  function automatic logic [11:0] samp(input int w, input int c, input int k);
    return 12'((w * 8 + k + c * 1024) & 'hFFF);
  endfunction

  function automatic logic [127:0] chan_word(input int w, input int c);
    logic [127:0] r;
    for (int k = 0; k < 8; k++) r[16*k +: 16] = {samp(w, c, k), 4'h5};
    return r;
  endfunction

  task automatic check(input bit ok, input string nm, input longint act, input longint req);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (edge %0d)", nm, act, req, widx);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    widx++;
    adc_a = chan_word(widx, 0);
    for (int c = 0; c < 4; c++) adc_b[128*c +: 128] = chan_word(widx, c);
  endtask

  // Expected readout: 8*n samples, words t-pre .. t-pre+n-1 of the latched channel.
  task automatic push_capture(input int d, input int t, input int pre, input int n, input int ch);
    exp_len[d] = 8 * n;
    rd_ptr[d]  = 0;
    vcnt[d]    = 0;
    for (int i = 0; i < 8 * n; i++) exp_mem[d][i] = samp(t - pre + i / 8, ch, i % 8);
  endtask

  task automatic check_cycle(input int d, input logic v, input logic [11:0] o, input logic a);
    if (a) begin
      ack_cnt[d]++;
      last_ack[d] = widx;
    end
    if (v) begin
      check(rd_ptr[d] < exp_len[d], d == 0 ? "unexpected_valid_a" : "unexpected_valid_b",
            rd_ptr[d], exp_len[d]);
      if (rd_ptr[d] < exp_len[d]) begin
        check(o == exp_mem[d][rd_ptr[d]], d == 0 ? "sample_a" : "sample_b",
              o, exp_mem[d][rd_ptr[d]]);
        rcv[d][rd_ptr[d]] = o;
        rd_ptr[d]++;
      end
      if (vcnt[d] == 0) first_v[d] = widx;
      vcnt[d]++;
      last_v[d] = widx;
    end else begin
      check(o == 12'd0, d == 0 ? "idle_out_a" : "idle_out_b", o, 0);
      check(!(vcnt[d] > 0 && rd_ptr[d] < exp_len[d]), d == 0 ? "gap_a" : "gap_b",
            rd_ptr[d], exp_len[d]);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      check_cycle(0, if_a.adc_valid, if_a.adc_out, if_a.trigger_ack);
      check_cycle(1, if_b.adc_valid, if_b.adc_out, if_b.trigger_ack);
    end
  end

  initial begin
    int ra, rr, rb, t, t2, g, k0;
    for (int d = 0; d < 2; d++) begin
      exp_len[d] = 0; rd_ptr[d] = 0; vcnt[d] = 0; first_v[d] = 0;
      last_v[d] = 0; ack_cnt[d] = 0; last_ack[d] = 0;
    end
    rst_a = 1'b1; rst_b = 1'b1;
    sel_a = 2'd3; sel_b = 2'd2;
    if_a.trigger_in = 1'b0; if_b.trigger_in = 1'b0;
    adc_a = chan_word(0, 0);
    for (int c = 0; c < 4; c++) adc_b[128*c +: 128] = chan_word(0, c);

    repeat (3) tick;
    check(if_a.adc_valid == 0,   "rst_valid_a", if_a.adc_valid, 0);
    check(if_a.adc_out == 0,     "rst_out_a",   if_a.adc_out, 0);
    check(if_a.trigger_ack == 0, "rst_ack_a",   if_a.trigger_ack, 0);
    check(if_a.armed == 0,       "rst_armed_a", if_a.armed, 0);
    check(if_b.armed == 0,       "rst_armed_b", if_b.armed, 0);
`ifdef ADC_ILA_CAPTURE_TIMESTAMP_EN
    check(tt_b == 0, "rst_trig_time_b", tt_b, 0);
`endif

    // ---------------- DUT A: defaults ----------------
    ra = widx;
    tick;
    rst_a = 1'b0;
    while (widx < ra + 3) tick;
    if_a.trigger_in = 1'b1;                 // edge during ARM: discarded
    tick;
    check(if_a.armed == 0, "armed_early_a", if_a.armed, 0);
    tick;
    if_a.trigger_in = 1'b0;
    while (widx < ra + 16) tick;
    check(if_a.armed == 0, "armed_pre_a", if_a.armed, 0);
    tick;
    check(if_a.armed == 1, "armed_rise_a", if_a.armed, 1);
    check(vcnt[0] == 0, "no_valid_early_a", vcnt[0], 0);

    t = widx;                               // first ARMED edge, trigger held high
    if_a.trigger_in = 1'b1;
    push_capture(0, t, PA, NA, 0);
    k0 = ack_cnt[0];
    g = 0;
    while (ack_cnt[0] == k0 && g < 3000) begin tick; g++; end
    check(ack_cnt[0] == k0 + 1, "ack_a1", ack_cnt[0], k0 + 1);
    check(vcnt[0] == 1024, "valid_count_a1", vcnt[0], 1024);
    check(rcv[0][128] == samp(t, 0, 0), "trig_word_a1", rcv[0][128], samp(t, 0, 0));
    check(rcv[0][0] == samp(t - 16, 0, 0), "oldest_word_a1", rcv[0][0], samp(t - 16, 0, 0));
    check(rcv[0][1023] == samp(t + 111, 0, 7), "newest_word_a1", rcv[0][1023], samp(t + 111, 0, 7));
    check(first_v[0] - (t + 111) >= 1 && first_v[0] - (t + 111) <= 3, "read_latency_a1",
          first_v[0] - (t + 111), 3);
    check(last_v[0] - first_v[0] == 1023, "no_gap_span_a1", last_v[0] - first_v[0], 1023);
    check(last_ack[0] - last_v[0] == HA + 1, "holdoff_a1", last_ack[0] - last_v[0], HA + 1);
    tick;
    check(if_a.trigger_ack == 0, "ack_one_clock_a", if_a.trigger_ack, 0);

    // trigger_in still high: no re-trigger while re-armed
    while (widx < last_ack[0] + 40) tick;
    check(if_a.armed == 1, "still_armed_a", if_a.armed, 1);
    check(vcnt[0] == 1024, "no_retrigger_a", vcnt[0], 1024);
    if_a.trigger_in = 1'b0;
    tick;
    if_a.trigger_in = 1'b1;
    t2 = widx;
    push_capture(0, t2, PA, NA, 0);
    repeat (4) tick;
    if_a.trigger_in = 1'b0;

    // reset in the middle of the readout
    g = 0;
    while (vcnt[0] < 501 && g < 3000) begin tick; g++; end
    check(vcnt[0] == 501, "reach_sample_500_a", vcnt[0], 501);
    k0 = ack_cnt[0];
    rst_a = 1'b1;
    exp_len[0] = rd_ptr[0];
    rr = widx;
    tick;
    rst_a = 1'b0;
    check(if_a.adc_valid == 0, "valid_after_rst_a", if_a.adc_valid, 0);
    check(if_a.armed == 0, "armed_after_rst_a", if_a.armed, 0);
    while (widx < rr + 16) tick;
    check(if_a.armed == 0, "rearm_pre_a", if_a.armed, 0);
    tick;
    check(if_a.armed == 1, "rearm_a", if_a.armed, 1);
    repeat (100) tick;
    check(ack_cnt[0] == k0, "no_ack_after_rst_a", ack_cnt[0], k0);

    // ---------------- DUT B: NCHAN=4, DEPTH_LOG2=5, PRETRIG=0 ----------------
    rb = widx;                              // chan_sel=2 latched here
    tick;
    rst_b = 1'b0;
    while (widx < rb + 1001) tick;          // timestamp counter reads 1000 at this edge
    check(if_b.armed == 1, "armed_b", if_b.armed, 1);
    if_b.trigger_in = 1'b1;
    t = widx;
    push_capture(1, t, PB, NB, 2);
    repeat (5) tick;
    sel_b = 2'd1;                           // mid-capture change has no effect
    if_b.trigger_in = 1'b0;
    k0 = ack_cnt[1];
    g = 0;
    while (ack_cnt[1] == k0 && g < 1000) begin tick; g++; end
    check(ack_cnt[1] == k0 + 1, "ack_b1", ack_cnt[1], k0 + 1);
    check(vcnt[1] == 256, "valid_count_b1", vcnt[1], 256);
    check(rcv[1][0] == samp(t, 2, 0), "first_is_trig_b1", rcv[1][0], samp(t, 2, 0));
    check(rcv[1][255] == samp(t + 31, 2, 7), "last_word_b1", rcv[1][255], samp(t + 31, 2, 7));
    check(first_v[1] - (t + 31) >= 1 && first_v[1] - (t + 31) <= 3, "read_latency_b1",
          first_v[1] - (t + 31), 3);
    check(last_ack[1] - last_v[1] == HB + 1, "holdoff_b1", last_ack[1] - last_v[1], HB + 1);
`ifdef ADC_ILA_CAPTURE_TIMESTAMP_EN
    check(tt_b == 32'd1000, "trig_time_b1", tt_b, 1000);
`endif

    // chan_sel=1 now latched at ARM re-entry
    while (widx < last_ack[1] + 6) tick;
`ifdef ADC_ILA_CAPTURE_TIMESTAMP_EN
    check(tt_b == 32'd1000, "trig_time_hold_b", tt_b, 1000);
`endif
    if_b.trigger_in = 1'b1;
    t2 = widx;
    push_capture(1, t2, PB, NB, 1);
    tick;
    if_b.trigger_in = 1'b0;
    k0 = ack_cnt[1];
    g = 0;
    while (ack_cnt[1] == k0 && g < 1000) begin tick; g++; end
    check(ack_cnt[1] == k0 + 1, "ack_b2", ack_cnt[1], k0 + 1);
    check(vcnt[1] == 256, "valid_count_b2", vcnt[1], 256);
    check(rcv[1][0] == samp(t2, 1, 0), "first_is_trig_b2", rcv[1][0], samp(t2, 1, 0));
`ifdef ADC_ILA_CAPTURE_TIMESTAMP_EN
    check(tt_b == 32'(t2 - rb - 1), "trig_time_b2", tt_b, t2 - rb - 1);
`endif
    repeat (3) tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_ila_capture.md
ADC_ILA_CAPTURE -- requirements
Module: adc_ila_capture

Interface
REQ-001 SHALL have parameter NCHAN, default 1: number of 128-bit ADC channel inputs, legal range 1..4.
REQ-002 SHALL have parameter DEPTH_LOG2, default 7: log2 of capture depth in ADC clocks (words), legal range 5..10.
REQ-003 SHALL have parameter PRETRIG, default 16: words retained before the trigger, legal range 0..2^DEPTH_LOG2-1.
REQ-004 SHALL have parameter HOLDOFF, default 32: idle clocks between end of readout and trigger_ack, legal range 1..255.
REQ-005 SHALL have port adc_clk, input, 1: sole clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port adc_in, input, NCHAN*128: per channel, 8 lanes of 16 bits; sample k is bits [16k+4 +: 12] of the channel word.
REQ-008 SHALL have port chan_sel, input, 2: selects the channel to capture; values >= NCHAN select channel 0.
REQ-009 SHALL have port trigger_in, input, 1: capture request, level from the ILA trigger out.
REQ-010 SHALL have port trigger_ack, output, 1: one-clock acknowledge pulse.
REQ-011 SHALL have port adc_out, output, 12: serialized sample.
REQ-012 SHALL have port adc_valid, output, 1: adc_out qualifier.
REQ-013 SHALL have port armed, output, 1: high only in state ARMED.

Function
REQ-014 SHALL implement states ARM, ARMED, POST, READ, WAIT, with a free-running circular write of the selected channel's 96 data bits into a 2^DEPTH_LOG2 x 96 RAM during ARM, ARMED and POST.
REQ-015 SHALL latch chan_sel on entry to ARM; chan_sel changes at any other time have no effect.
REQ-016 SHALL stay in ARM for exactly PRETRIG write cycles, then go to ARMED; with PRETRIG=0 it SHALL go to ARMED the cycle after entering ARM.
REQ-017 SHALL detect a trigger as a trigger_in 0->1 edge (registered previous value); edges seen in ARM, POST, READ or WAIT are discarded, not queued.
REQ-018 SHALL, on a trigger in ARMED, treat the word written in that same cycle as post-trigger word 0, record its address, and go to POST.
REQ-019 SHALL write exactly 2^DEPTH_LOG2-PRETRIG words in total in ARMED-trigger-cycle plus POST, then stop writing and go to READ.
REQ-020 SHALL, in READ, output 8*2^DEPTH_LOG2 samples on consecutive clocks with adc_valid high continuously, oldest word first, lane 0 to lane 7 within each word.
REQ-021 SHALL place the first trigger-word sample at readout index 8*PRETRIG (zero-based).
REQ-022 SHALL make the first adc_valid no more than 3 clocks after entering READ; RAM read latency SHALL be hidden so there are no gaps.
REQ-023 SHALL hold adc_out at 0 whenever adc_valid is low.
REQ-024 SHALL, after the last sample, go to WAIT for HOLDOFF clocks, pulse trigger_ack for exactly one clock, then enter ARM.
REQ-025 SHALL use the address counter modulo 2^DEPTH_LOG2 and wrap without a bubble.

Reset
REQ-026 SHALL, on rst, clear outputs to trigger_ack=0, adc_valid=0, adc_out=0, armed=0, reset the state to ARM, and zero the counters and the edge-detect register.
REQ-027 SHALL treat rst in any state, including mid-READ, as ending that operation at the next edge with no further valid samples and no trigger_ack; RAM contents need not be cleared.

Configuration
REQ-028 SHALL add output trig_time[31:0] when ADC_ILA_CAPTURE_TIMESTAMP_EN is defined: a free-running 32-bit adc_clk counter, cleared by rst, latched at the accepted trigger, and held until the next accepted trigger.
REQ-029 SHALL, without ADC_ILA_CAPTURE_TIMESTAMP_EN, have no trig_time port and no counter.

Verification
REQ-030 SHALL cover: defaults, adc_in lane k = word index*8+k ramp, trigger at ARMED -> 1024 valid clocks, sample at index 128 equals the trigger-word lane 0 value, trigger_ack pulses 32 clocks after the last valid.
REQ-031 SHALL cover: trigger_in held high through the entire capture -> exactly one capture, no re-trigger until trigger_in falls and rises again in ARMED.
REQ-032 SHALL cover: trigger edge 3 clocks after rst (PRETRIG=16) -> ignored, armed still 0, no adc_valid.
REQ-033 SHALL cover: NCHAN=4, chan_sel=2 at ARM entry, chan_sel=1 mid-capture -> all samples come from channel 2.
REQ-034 SHALL cover: rst asserted at readout sample 500 -> adc_valid 0 the next clock, no trigger_ack, armed after 16 clocks.
REQ-035 SHALL cover: PRETRIG=0, DEPTH_LOG2=5, timestamp enabled, trigger at counter 1000 -> first sample is the trigger word, 256 valids, trig_time=1000.
